// File: rtl/bcd_pkg.sv
// Purpose: shared BCD helpers and constants for the decimal counter and its digit cells.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Exports: BCD_NINE, to_bcd() for compile-time BCD constants, bcd_valid() nibble check.
package bcd_pkg;

   localparam logic [3:0] BCD_NINE = 4'd9;

   // Converts a non-negative integer to packed BCD, up to 8 decades; digit 0 in [3:0].
   function automatic logic [31:0] to_bcd(input int val);
      logic [31:0] r;
      int          v;
      r = '0;
      v = val;
      for (int i = 0; i < 8; i++) begin
         r[i*4 +: 4] = 4'(v % 10);
         v           = v / 10;
      end
      return r;
   endfunction

   function automatic logic bcd_valid(input logic [3:0] nib);
      return (nib <= BCD_NINE);
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// Purpose: one BCD decade register with increment/decrement/clear/set controls.
// Latency: 1 cycle from controls to o_q; o_is9/o_is0 decode the registered value.
// Backpressure: none; controls are acted on every cycle (priority set > clr > inc > dec).
// Ports: i_clk, i_rst (async, active-high), i_inc, i_dec, i_clr, i_set, i_set_val[3:0],
//        o_q[3:0] digit value, o_is9 / o_is0 digit-at-9 / digit-at-0 flags for the ripple chain.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_inc,
   input  logic       i_dec,
   input  logic       i_clr,
   input  logic       i_set,
   input  logic [3:0] i_set_val,
   output logic [3:0] o_q,
   output logic       o_is9,
   output logic       o_is0
);

   logic [3:0] r_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_q <= 4'd0;
      end else if (i_set) begin
         r_q <= i_set_val;
      end else if (i_clr) begin
         r_q <= 4'd0;
      end else if (i_inc) begin
         r_q <= (r_q == BCD_NINE) ? 4'd0 : r_q + 4'd1;
      end else if (i_dec) begin
         r_q <= (r_q == 4'd0) ? BCD_NINE : r_q - 4'd1;
      end
   end

   assign o_q   = r_q;
   assign o_is9 = (r_q == BCD_NINE);
   assign o_is0 = (r_q == 4'd0);

endmodule

// File: rtl/bcd_counter_ndigit.sv
// Purpose: N-digit packed-BCD up/down counter with modulus CMAX, wrap/saturate, validated load.
// Latency: 1 cycle from sampled inputs to o_count_bcd, o_tc and o_load_err.
// Backpressure: none; i_load and i_en are sampled every cycle, priority rst > load > en.
// Ports: i_clk, i_rst (async, active-high), i_en count tick, i_updown (1=up), i_load level,
//        i_data_in packed BCD load value; o_count_bcd count, o_tc terminal-count pulse,
//        o_load_err rejected-load pulse.
module bcd_counter_ndigit
   import bcd_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int CMAX   = 1000,
   parameter bit WRAP   = 1'b1
)(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_en,
   input  logic                i_updown,
   input  logic                i_load,
   input  logic [4*DIGITS-1:0] i_data_in,
   output logic [4*DIGITS-1:0] o_count_bcd,
   output logic                o_tc,
   output logic                o_load_err
);

   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("bcd_counter_ndigit: DIGITS must be in 1..8");
   end
   if (CMAX < 2 || CMAX > 10**DIGITS) begin : g_bad_cmax
      $error("bcd_counter_ndigit: CMAX must be in 2..10**DIGITS");
   end

   localparam logic [31:0]         MAX_BCD_FULL = to_bcd(CMAX - 1);
   localparam logic [4*DIGITS-1:0] MAX_BCD      = MAX_BCD_FULL[4*DIGITS-1:0];

   logic [4*DIGITS-1:0] w_q;
   logic [4*DIGITS-1:0] w_set_val;
   logic [DIGITS-1:0]   w_is9;
   logic [DIGITS-1:0]   w_is0;
   logic [DIGITS-1:0]   w_up_run;
   logic [DIGITS-1:0]   w_dn_run;
   logic [DIGITS-1:0]   w_dig_max;
   logic [DIGITS-1:0]   w_inc;
   logic [DIGITS-1:0]   w_dec;
   logic                w_nib_ok;
   logic                w_load_ok;
   logic                w_at_max;
   logic                w_at_zero;
   logic                w_count_cyc;
   logic                w_step_up;
   logic                w_step_dn;
   logic                w_wrap_up;
   logic                w_wrap_dn;
   logic                w_set;
   logic                w_limit_hit;
   logic                r_tc;
   logic                r_load_err;

   // Ripple enables: digit i moves only when every lower digit is 9 (up) or 0 (down).
   // Limit compare is per digit against MAX_BCD; 9s and 0s reuse the digit flags.
   always_comb begin
      w_nib_ok  = 1'b1;
      w_up_run  = '0;
      w_dn_run  = '0;
      w_dig_max = '0;
      w_up_run[0] = 1'b1;
      w_dn_run[0] = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         w_nib_ok = w_nib_ok & bcd_valid(i_data_in[i*4 +: 4]);
         if (i > 0) begin
            w_up_run[i] = w_up_run[i-1] & w_is9[i-1];
            w_dn_run[i] = w_dn_run[i-1] & w_is0[i-1];
         end
         if (MAX_BCD[i*4 +: 4] == BCD_NINE) begin
            w_dig_max[i] = w_is9[i];
         end else if (MAX_BCD[i*4 +: 4] == 4'd0) begin
            w_dig_max[i] = w_is0[i];
         end else begin
            w_dig_max[i] = (w_q[i*4 +: 4] == MAX_BCD[i*4 +: 4]);
         end
      end
   end

   assign w_at_max  = &w_dig_max;
   assign w_at_zero = &w_is0;

   // With all nibbles <= 9, packed-BCD ordering equals plain unsigned ordering.
   assign w_load_ok = w_nib_ok & (i_data_in <= MAX_BCD);

   // A load in the same cycle swallows the count step and its tc.
   assign w_count_cyc = i_en & ~i_load;
   assign w_step_up   = w_count_cyc &  i_updown & ~w_at_max;
   assign w_step_dn   = w_count_cyc & ~i_updown & ~w_at_zero;
   assign w_wrap_up   = w_count_cyc &  i_updown & w_at_max  & WRAP;
   assign w_wrap_dn   = w_count_cyc & ~i_updown & w_at_zero & WRAP;
   assign w_limit_hit = w_count_cyc & (i_updown ? w_at_max : w_at_zero);

   assign w_inc     = {DIGITS{w_step_up}} & w_up_run;
   assign w_dec     = {DIGITS{w_step_dn}} & w_dn_run;
   assign w_set     = (i_load & w_load_ok) | w_wrap_dn;
   assign w_set_val = i_load ? i_data_in : MAX_BCD;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_inc     (w_inc[g]),
         .i_dec     (w_dec[g]),
         .i_clr     (w_wrap_up),
         .i_set     (w_set),
         .i_set_val (w_set_val[g*4 +: 4]),
         .o_q       (w_q[g*4 +: 4]),
         .o_is9     (w_is9[g]),
         .o_is0     (w_is0[g])
      );
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tc       <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_tc       <= w_limit_hit;
         r_load_err <= i_load & ~w_load_ok;
      end
   end

   assign o_count_bcd = w_q;
   assign o_tc        = r_tc;
   assign o_load_err  = r_load_err;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Purpose: self-checking bench for bcd_counter_ndigit (3-digit CMAX=100 wrap and saturate, 4-digit CMAX=10000).
// Latency: checks sample 1 time unit after the rising edge that consumed each input set.
// Backpressure: n/a.
module tb_bcd_counter_ndigit;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        updown;
   logic        load;
   logic [11:0] din;
   logic [15:0] din_c;
   logic [11:0] cnt_a, cnt_b;
   logic [15:0] cnt_c;
   logic        tc_a, tc_b, tc_c;
   logic        err_a, err_b, err_c;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   bcd_counter_ndigit #(.DIGITS(3), .CMAX(100), .WRAP(1'b1)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_updown(updown), .i_load(load),
      .i_data_in(din), .o_count_bcd(cnt_a), .o_tc(tc_a), .o_load_err(err_a));

   bcd_counter_ndigit #(.DIGITS(3), .CMAX(100), .WRAP(1'b0)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_updown(updown), .i_load(load),
      .i_data_in(din), .o_count_bcd(cnt_b), .o_tc(tc_b), .o_load_err(err_b));

   bcd_counter_ndigit #(.DIGITS(4), .CMAX(10000), .WRAP(1'b1)) dut_c (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_updown(updown), .i_load(load),
      .i_data_in(din_c), .o_count_bcd(cnt_c), .o_tc(tc_c), .o_load_err(err_c));

   typedef struct {
      logic        ld;
      logic        en;
      logic        up;
      logic [11:0] din;
      logic [11:0] ea;
      logic        ta;
      logic        xa;
      logic [11:0] eb;
      logic        tb;
      logic        xb;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tot++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic drive(input logic ld, input logic e, input logic up,
                        input logic [11:0] d, input logic [15:0] dc);
      @(negedge clk);
      load   = ld;
      en     = e;
      updown = up;
      din    = d;
      din_c  = dc;
      @(posedge clk);
      #1;
   endtask

   task automatic cstep(input string name, input logic ld, input logic e, input logic up,
                        input logic [15:0] dc, input logic [15:0] exp_cnt, input logic exp_tc);
      drive(ld, e, up, 12'h000, dc);
      chk({name, " cnt_c"}, cnt_c, exp_cnt);
      chk({name, " tc_c"}, {15'd0, tc_c}, {15'd0, exp_tc});
   endtask

   initial begin
      //          ld en up din     | A: cnt  tc err | B: cnt  tc err
      vecs[0]  = '{1, 0, 1, 12'h098, 12'h098, 0, 0, 12'h098, 0, 0};
      vecs[1]  = '{0, 1, 1, 12'h000, 12'h099, 0, 0, 12'h099, 0, 0};
      vecs[2]  = '{0, 0, 1, 12'h000, 12'h099, 0, 0, 12'h099, 0, 0};
      vecs[3]  = '{0, 1, 1, 12'h000, 12'h000, 1, 0, 12'h099, 1, 0};
      vecs[4]  = '{0, 1, 1, 12'h000, 12'h001, 0, 0, 12'h099, 1, 0};
      vecs[5]  = '{0, 0, 1, 12'h000, 12'h001, 0, 0, 12'h099, 0, 0};
      vecs[6]  = '{1, 0, 1, 12'h0A5, 12'h001, 0, 1, 12'h099, 0, 1};
      vecs[7]  = '{1, 0, 1, 12'h100, 12'h001, 0, 1, 12'h099, 0, 1};
      vecs[8]  = '{1, 0, 1, 12'h042, 12'h042, 0, 0, 12'h042, 0, 0};
      vecs[9]  = '{1, 0, 1, 12'h099, 12'h099, 0, 0, 12'h099, 0, 0};
      vecs[10] = '{1, 1, 1, 12'h042, 12'h042, 0, 0, 12'h042, 0, 0};
      vecs[11] = '{1, 0, 1, 12'h001, 12'h001, 0, 0, 12'h001, 0, 0};
      vecs[12] = '{0, 1, 0, 12'h000, 12'h000, 0, 0, 12'h000, 0, 0};
      vecs[13] = '{0, 1, 0, 12'h000, 12'h099, 1, 0, 12'h000, 1, 0};
      vecs[14] = '{0, 1, 0, 12'h000, 12'h098, 0, 0, 12'h000, 1, 0};
      vecs[15] = '{1, 0, 0, 12'h09F, 12'h098, 0, 1, 12'h000, 0, 1};
      vecs[16] = '{1, 1, 0, 12'h09F, 12'h098, 0, 1, 12'h000, 0, 1};
      vecs[17] = '{0, 1, 1, 12'h000, 12'h099, 0, 0, 12'h001, 0, 0};
      vecs[18] = '{0, 1, 0, 12'h000, 12'h098, 0, 0, 12'h000, 0, 0};
      vecs[19] = '{0, 0, 1, 12'h000, 12'h098, 0, 0, 12'h000, 0, 0};

      rst    = 1'b1;
      en     = 1'b0;
      updown = 1'b1;
      load   = 1'b0;
      din    = 12'h000;
      din_c  = 16'h0000;
      #2;
      chk("rst cnt_a", {4'd0, cnt_a}, 16'h0000);
      chk("rst cnt_c", cnt_c, 16'h0000);
      chk("rst tc_a",  {15'd0, tc_a},  16'h0000);
      chk("rst err_a", {15'd0, err_a}, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].din, 16'h0000);
         chk($sformatf("v%0d cnt_a", i), {4'd0, cnt_a}, {4'd0, vecs[i].ea});
         chk($sformatf("v%0d tc_a", i),  {15'd0, tc_a},  {15'd0, vecs[i].ta});
         chk($sformatf("v%0d err_a", i), {15'd0, err_a}, {15'd0, vecs[i].xa});
         chk($sformatf("v%0d cnt_b", i), {4'd0, cnt_b}, {4'd0, vecs[i].eb});
         chk($sformatf("v%0d tc_b", i),  {15'd0, tc_b},  {15'd0, vecs[i].tb});
         chk($sformatf("v%0d err_b", i), {15'd0, err_b}, {15'd0, vecs[i].xb});
      end

      // Asynchronous reset mid-count at 0x057 with load_err high, between clock edges.
      drive(1, 0, 1, 12'h056, 16'h0000);
      drive(0, 1, 1, 12'h000, 16'h0000);
      chk("pre_rst cnt_a", {4'd0, cnt_a}, 16'h0057);
      drive(1, 0, 1, 12'h0FF, 16'h0000);
      chk("pre_rst err_a", {15'd0, err_a}, 16'h0001);
      load = 1'b0;
      en   = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst cnt_a", {4'd0, cnt_a}, 16'h0000);
      chk("async_rst tc_a",  {15'd0, tc_a},  16'h0000);
      chk("async_rst err_a", {15'd0, err_a}, 16'h0000);
      chk("async_rst cnt_b", {4'd0, cnt_b}, 16'h0000);
      #1;
      rst = 1'b0;
      drive(0, 1, 1, 12'h000, 16'h0000);
      chk("post_rst cnt_a", {4'd0, cnt_a}, 16'h0001);

      // Four-digit instance: full carry and borrow ripples.
      cstep("c_ld9999",    1, 0, 1, 16'h9999, 16'h9999, 1'b0);
      cstep("c_up_wrap",   0, 1, 1, 16'h0000, 16'h0000, 1'b1);
      cstep("c_ld1000",    1, 0, 1, 16'h1000, 16'h1000, 1'b0);
      cstep("c_dn_ripple", 0, 1, 0, 16'h0000, 16'h0999, 1'b0);
      cstep("c_ld0129",    1, 0, 1, 16'h0129, 16'h0129, 1'b0);
      cstep("c_up_0130",   0, 1, 1, 16'h0000, 16'h0130, 1'b0);
      cstep("c_ld0099",    1, 0, 1, 16'h0099, 16'h0099, 1'b0);
      cstep("c_up_0100",   0, 1, 1, 16'h0000, 16'h0100, 1'b0);
      cstep("c_dn_0099",   0, 1, 0, 16'h0000, 16'h0099, 1'b0);
      cstep("c_ldbad",     1, 0, 0, 16'hA000, 16'h0099, 1'b0);
      chk("c_ldbad err_c", {15'd0, err_c}, 16'h0001);
      cstep("c_ld0000",    1, 0, 0, 16'h0000, 16'h0000, 1'b0);
      chk("c_ld0000 err_c", {15'd0, err_c}, 16'h0000);
      cstep("c_dn_wrap",   0, 1, 0, 16'h0000, 16'h9999, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
